// File: rtl/tmp421_measure_fsm.sv
// tmp421_measure_fsm: serves local/remote temperature queries for a TMP421.
// Each query runs four I2C transfers: pointer write, then a 1-byte read of the
// high byte, then the same pair for the low byte. The sequence ends with a
// one-cycle Done pulse (bytes valid) or a one-cycle Error pulse.
module tmp421_measure_fsm #(
  parameter int unsigned DataWidth = 8,
  parameter logic [6:0]  I2CAddr   = 7'h4C
) (
  input  logic                 Reset_n_i,
  input  logic                 Clk_i,
  input  logic                 QueryLocal_i,
  input  logic                 QueryRemote_i,
  output logic                 Done_o,
  output logic                 Error_o,
  output logic [DataWidth-1:0] Byte0_o,
  output logic [DataWidth-1:0] Byte1_o,
  output logic                 I2C_ReceiveSend_n_o,
  output logic [3:0]           I2C_ReadCount_o,
  output logic                 I2C_StartProcess_o,
  input  logic                 I2C_Busy_i,
  output logic                 I2C_FIFOReadNext_o,
  output logic                 I2C_FIFOWrite_o,
  output logic [DataWidth-1:0] I2C_Data_o,
  input  logic [DataWidth-1:0] I2C_Data_i,
  input  logic                 I2C_Error_i
);

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrPtr,
    StStartW,
    StWaitW,
    StStartR,
    StWaitR,
    StDone,
    StError
  } state_e;

  localparam logic [DataWidth-1:0] AddrWrite = DataWidth'({I2CAddr, 1'b0});
  localparam logic [DataWidth-1:0] AddrRead  = DataWidth'({I2CAddr, 1'b1});

  state_e               state;
  logic                 sel;    // 0 = local, 1 = remote
  logic                 phase;  // 0 = high byte, 1 = low byte
  logic                 wr_strobe;
  logic [DataWidth-1:0] wr_data;
  logic [7:0]           pointer;
  logic                 xfer_ok;

  // Register pointer: 0x00/0x01 for the high byte, 0x10/0x11 for the low byte.
  assign pointer = {3'b000, phase, 3'b000, sel};
  // Core finished the current transfer without error.
  assign xfer_ok = !I2C_Busy_i && !I2C_Error_i;

  // Sequencer state, captured bytes and the state-determined registered outputs.
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state               <= StIdle;
      sel                 <= 1'b0;
      phase               <= 1'b0;
      Byte0_o             <= '0;
      Byte1_o             <= '0;
      wr_strobe           <= 1'b0;
      wr_data             <= '0;
      I2C_StartProcess_o  <= 1'b0;
      I2C_ReceiveSend_n_o <= 1'b0;
      I2C_ReadCount_o     <= 4'd0;
      Done_o              <= 1'b0;
      Error_o             <= 1'b0;
    end else begin
      // Outputs are set on the edge that enters the state they belong to.
      wr_strobe           <= 1'b0;
      wr_data             <= '0;
      I2C_StartProcess_o  <= 1'b0;
      I2C_ReceiveSend_n_o <= 1'b0;
      I2C_ReadCount_o     <= 4'd0;
      Done_o              <= 1'b0;
      Error_o             <= 1'b0;
      unique case (state)
        StIdle: begin
          if (QueryLocal_i || QueryRemote_i) begin
            sel       <= !QueryLocal_i;  // local wins a simultaneous request
            phase     <= 1'b0;
            state     <= StWrAddr;
            wr_strobe <= 1'b1;
            wr_data   <= AddrWrite;
          end
        end
        StWrAddr: begin
          state     <= StWrPtr;
          wr_strobe <= 1'b1;
          wr_data   <= DataWidth'(pointer);
        end
        StWrPtr: begin
          state              <= StStartW;
          I2C_StartProcess_o <= 1'b1;
        end
        StStartW: begin
          state <= StWaitW;
        end
        StWaitW: begin
          if (!I2C_Busy_i) begin
            if (I2C_Error_i) begin
              state   <= StError;
              Error_o <= 1'b1;
            end else begin
              state               <= StStartR;
              I2C_StartProcess_o  <= 1'b1;
              I2C_ReceiveSend_n_o <= 1'b1;
              I2C_ReadCount_o     <= 4'd1;
            end
          end
        end
        StStartR: begin
          state               <= StWaitR;
          I2C_ReceiveSend_n_o <= 1'b1;
          I2C_ReadCount_o     <= 4'd1;
        end
        StWaitR: begin
          if (I2C_Busy_i) begin
            I2C_ReceiveSend_n_o <= 1'b1;
            I2C_ReadCount_o     <= 4'd1;
          end else if (I2C_Error_i) begin
            state   <= StError;
            Error_o <= 1'b1;
          end else if (!phase) begin
            Byte1_o   <= I2C_Data_i;
            phase     <= 1'b1;
            state     <= StWrAddr;
            wr_strobe <= 1'b1;
            wr_data   <= AddrWrite;
          end else begin
            Byte0_o <= I2C_Data_i;
            state   <= StDone;
            Done_o  <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        StError: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Strobes that depend on the core finishing in the current cycle.
  always_comb begin
    I2C_FIFOWrite_o    = wr_strobe;
    I2C_Data_o         = wr_data;
    I2C_FIFOReadNext_o = 1'b0;
    if (state == StWaitW && xfer_ok) begin
      I2C_FIFOWrite_o = 1'b1;
      I2C_Data_o      = AddrRead;
    end
    if (state == StWaitR && xfer_ok) begin
      I2C_FIFOReadNext_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_tmp421_measure_fsm.sv
// Bench for tmp421_measure_fsm: behavioural I2C core model plus a
// transaction-level reference (expected FIFO byte list, event cycle, bytes).
module tb_tmp421_measure_fsm;

  localparam logic [7:0] AW = 8'h98;  // address + write
  localparam logic [7:0] AR = 8'h99;  // address + read

  logic       clk = 1'b0;
  logic       Reset_n_i = 1'b0;
  logic       QueryLocal_i = 1'b0;
  logic       QueryRemote_i = 1'b0;
  logic       Done_o, Error_o;
  logic [7:0] Byte0_o, Byte1_o;
  logic       I2C_ReceiveSend_n_o;
  logic [3:0] I2C_ReadCount_o;
  logic       I2C_StartProcess_o;
  logic       I2C_Busy_i = 1'b0;
  logic       I2C_FIFOReadNext_o, I2C_FIFOWrite_o;
  logic [7:0] I2C_Data_o;
  logic [7:0] I2C_Data_i = 8'h00;
  logic       I2C_Error_i = 1'b0;

  always #5 clk = ~clk;

  tmp421_measure_fsm dut (
    .Reset_n_i          (Reset_n_i),
    .Clk_i              (clk),
    .QueryLocal_i       (QueryLocal_i),
    .QueryRemote_i      (QueryRemote_i),
    .Done_o             (Done_o),
    .Error_o            (Error_o),
    .Byte0_o            (Byte0_o),
    .Byte1_o            (Byte1_o),
    .I2C_ReceiveSend_n_o(I2C_ReceiveSend_n_o),
    .I2C_ReadCount_o    (I2C_ReadCount_o),
    .I2C_StartProcess_o (I2C_StartProcess_o),
    .I2C_Busy_i         (I2C_Busy_i),
    .I2C_FIFOReadNext_o (I2C_FIFOReadNext_o),
    .I2C_FIFOWrite_o    (I2C_FIFOWrite_o),
    .I2C_Data_o         (I2C_Data_o),
    .I2C_Data_i         (I2C_Data_i),
    .I2C_Error_i        (I2C_Error_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Core model configuration and state
  int         busy_len = 3;
  int         err_at = -1;
  int         xfer_idx = 0;
  int         busy_cnt = 0;
  bit         cur_err, cur_read;
  logic [7:0] rd_q[$];

  // Monitor state
  logic [7:0] wr_q[$];
  int         n_done, n_err, n_start, n_rd_start, n_pop, rc_bad, done_cyc, err_cyc;
  logic [7:0] done_b0, done_b1;
  bit         start_prev = 1'b0, rsn_prev = 1'b0;

  // Reference model state
  int         q_cyc;
  logic [7:0] m_b0, m_b1;

  always @(posedge clk) cyc <= cyc + 1;

  // I2C core: Busy high for busy_len cycles starting the cycle after Start.
  always begin
    @(posedge clk);
    #1;
    if (start_prev) begin
      busy_cnt   = busy_len;
      cur_err    = (xfer_idx == err_at);
      cur_read   = rsn_prev;
      xfer_idx   = xfer_idx + 1;
      I2C_Data_i = 8'($urandom);
    end
    if (busy_cnt > 0) begin
      I2C_Busy_i  = 1'b1;
      I2C_Error_i = 1'b0;
      busy_cnt    = busy_cnt - 1;
    end else begin
      if (I2C_Busy_i) begin
        I2C_Error_i = cur_err;
        if (cur_read && !cur_err && rd_q.size() > 0) I2C_Data_i = rd_q.pop_front();
      end
      I2C_Busy_i = 1'b0;
    end
  end

  // Mid-cycle monitor of DUT outputs
  always @(negedge clk) begin
    start_prev = (I2C_StartProcess_o === 1'b1);
    rsn_prev   = (I2C_ReceiveSend_n_o === 1'b1);
    if (I2C_FIFOWrite_o === 1'b1) wr_q.push_back(I2C_Data_o);
    if (I2C_StartProcess_o === 1'b1) begin
      n_start++;
      if (rsn_prev) begin
        n_rd_start++;
        if (I2C_ReadCount_o !== 4'd1) rc_bad++;
      end else if (I2C_ReadCount_o !== 4'd0) rc_bad++;
    end
    if (I2C_FIFOReadNext_o === 1'b1) n_pop++;
    if (Done_o === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      done_b0  = Byte0_o;
      done_b1  = Byte1_o;
    end
    if (Error_o === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    n_done = 0; n_err = 0; n_start = 0; n_rd_start = 0; n_pop = 0; rc_bad = 0;
    done_cyc = -1; err_cyc = -1;
    xfer_idx = 0;
  endtask

  // Caller sits 1 time unit after a rising edge; returns likewise one cycle later.
  task automatic start_query(input bit loc, input bit rem);
    QueryLocal_i  = loc;
    QueryRemote_i = rem;
    q_cyc = cyc;
    @(posedge clk);
    #1;
    QueryLocal_i  = 1'b0;
    QueryRemote_i = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_done + n_err >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // One query, checked at transaction level against the reference model.
  task automatic run_query(input bit loc, input bit rem, input logic [7:0] hi,
                           input logic [7:0] lo, input int b, input int ea,
                           input bit extra, input string name);
    logic [7:0] exp_w[$];
    int         pre[4] = '{2, 3, 5, 6};
    bit         sel;
    bit         ok;
    int         last, n_w, s, e, exp_cyc, exp_pops, exp_rd;
    sel = !loc;
    clear_mon();
    busy_len = b;
    err_at   = ea;
    rd_q     = '{hi, lo};
    exp_w    = '{AW, 8'(sel), AR, AW, 8'h10 + 8'(sel), AR};
    start_query(loc, rem);
    if (extra) begin
      // A query arriving mid-sequence must be ignored.
      repeat (3) begin @(posedge clk); #1; end
      QueryLocal_i = 1'b1; QueryRemote_i = 1'b1;
      @(posedge clk); #1;
      QueryLocal_i = 1'b0; QueryRemote_i = 1'b0;
    end
    wait_events(1, 200, ok);
    repeat (8) begin @(posedge clk); #1; end

    last = (ea < 0) ? 3 : ea;
    n_w  = (ea < 0) ? 6 : pre[ea];
    s = 3; e = 0; exp_pops = 0; exp_rd = 0;
    for (int j = 0; j <= last; j++) begin
      e = s + b + 1;
      s = e + ((j % 2 == 0) ? 1 : 3);
      if (j % 2 == 1) begin
        exp_rd++;
        if (j != ea) exp_pops++;
      end
    end
    exp_cyc = q_cyc + e + 1;
    if (ea < 0) begin
      m_b1 = hi; m_b0 = lo;
    end else if (ea >= 2) begin
      m_b1 = hi;
    end

    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout: no Done/Error within budget", name); end
    checks++;
    if (n_done !== ((ea < 0) ? 1 : 0)) begin
      errors++; $display("FAIL %s done_count: got %0d want %0d", name, n_done, (ea < 0) ? 1 : 0);
    end
    checks++;
    if (n_err !== ((ea < 0) ? 0 : 1)) begin
      errors++; $display("FAIL %s error_count: got %0d want %0d", name, n_err, (ea < 0) ? 0 : 1);
    end
    checks++;
    if (((ea < 0) ? done_cyc : err_cyc) !== exp_cyc) begin
      errors++;
      $display("FAIL %s event_cycle: got %0d want %0d", name,
               (ea < 0) ? done_cyc : err_cyc, exp_cyc);
    end
    checks++;
    if (wr_q.size() !== n_w) begin
      errors++; $display("FAIL %s fifo_write_count: got %0d want %0d", name, wr_q.size(), n_w);
    end
    for (int j = 0; j < n_w && j < wr_q.size(); j++) begin
      checks++;
      if (wr_q[j] !== exp_w[j]) begin
        errors++; $display("FAIL %s fifo_byte[%0d]: got %02h want %02h", name, j, wr_q[j], exp_w[j]);
      end
    end
    checks++;
    if (n_start !== last + 1 || n_rd_start !== exp_rd) begin
      errors++;
      $display("FAIL %s starts: got %0d/%0d reads want %0d/%0d", name, n_start, n_rd_start,
               last + 1, exp_rd);
    end
    checks++;
    if (n_pop !== exp_pops) begin
      errors++; $display("FAIL %s fifo_pops: got %0d want %0d", name, n_pop, exp_pops);
    end
    checks++;
    if (rc_bad !== 0) begin
      errors++; $display("FAIL %s read_count: got %0d bad starts want 0", name, rc_bad);
    end
    if (ea < 0) begin
      checks++;
      if (done_b1 !== hi || done_b0 !== lo) begin
        errors++;
        $display("FAIL %s done_bytes: got %02h/%02h want %02h/%02h", name, done_b1, done_b0, hi, lo);
      end
    end
    checks++;
    if (Byte1_o !== m_b1 || Byte0_o !== m_b0) begin
      errors++;
      $display("FAIL %s held_bytes: got %02h/%02h want %02h/%02h", name, Byte1_o, Byte0_o,
               m_b1, m_b0);
    end
  endtask

  task automatic test_reset();
    Reset_n_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({Done_o, Error_o, I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_FIFOReadNext_o,
         I2C_ReceiveSend_n_o, I2C_ReadCount_o, I2C_Data_o} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero control outputs want all 0");
    end
    checks++;
    if (Byte0_o !== 8'h00 || Byte1_o !== 8'h00) begin
      errors++; $display("FAIL reset_bytes: got %02h/%02h want 00/00", Byte1_o, Byte0_o);
    end
    m_b0 = 8'h00; m_b1 = 8'h00;
    Reset_n_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_local_example();
    run_query(1'b1, 1'b0, 8'h19, 8'h80, 3, -1, 1'b0, "local_b3");
    checks++;
    if (done_cyc - q_cyc !== 25) begin
      errors++; $display("FAIL local_b3 latency: got %0d want 25", done_cyc - q_cyc);
    end
  endtask

  task automatic test_remote();
    run_query(1'b0, 1'b1, 8'hE7, 8'h40, 2, -1, 1'b0, "remote");
  endtask

  task automatic test_both_queries();
    run_query(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1, -1, 1'b0, "both_queries");
  endtask

  task automatic test_error();
    run_query(1'b1, 1'b0, 8'h55, 8'hAA, 2, 0, 1'b0, "error_first_write");
    run_query(1'b0, 1'b1, 8'h3C, 8'hC3, 1, 3, 1'b0, "error_last_read");
  endtask

  task automatic test_back_to_back();
    logic [7:0] h1, l1, h2, l2;
    int         b, q1, q2;
    bit         ok;
    h1 = 8'($urandom); l1 = 8'($urandom); h2 = 8'($urandom); l2 = 8'($urandom);
    b = int'($urandom_range(1, 4));
    clear_mon();
    busy_len = b; err_at = -1;
    rd_q = '{h1, l1, h2, l2};
    start_query(1'b1, 1'b0);
    q1 = q_cyc;
    wait_events(1, 200, ok);
    checks++;
    if (!ok || done_cyc !== q1 + 13 + 4 * b) begin
      errors++; $display("FAIL b2b_first_done: got cycle %0d want %0d", done_cyc - q1, 13 + 4 * b);
    end
    // Now in the cycle right after Done.
    start_query(1'b0, 1'b1);
    q2 = q_cyc;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (Byte1_o !== h1 || Byte0_o !== l1) begin
      errors++; $display("FAIL b2b_hold: got %02h/%02h want %02h/%02h", Byte1_o, Byte0_o, h1, l1);
    end
    wait_events(2, 200, ok);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (!ok || n_done !== 2 || done_cyc !== q2 + 13 + 4 * b) begin
      errors++;
      $display("FAIL b2b_second_done: got count %0d cycle %0d want 2 cycle %0d", n_done,
               done_cyc - q2, 13 + 4 * b);
    end
    checks++;
    if (done_b1 !== h2 || done_b0 !== l2) begin
      errors++; $display("FAIL b2b_bytes: got %02h/%02h want %02h/%02h", done_b1, done_b0, h2, l2);
    end
    checks++;
    if (wr_q.size() !== 12) begin
      errors++; $display("FAIL b2b_writes: got %0d want 12", wr_q.size());
    end else begin
      checks++;
      if (wr_q[1] !== 8'h00 || wr_q[4] !== 8'h10 || wr_q[7] !== 8'h01 || wr_q[10] !== 8'h11) begin
        errors++;
        $display("FAIL b2b_pointers: got %02h %02h %02h %02h want 00 10 01 11", wr_q[1], wr_q[4],
                 wr_q[7], wr_q[10]);
      end
    end
    m_b1 = h2; m_b0 = l2;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    busy_len = 6; err_at = -1;
    rd_q = '{8'h11, 8'h22};
    start_query(1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (n_rd_start >= 1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_reach: got no read start want one"); end
    // Inside the read wait: abort with reset.
    Reset_n_i = 1'b0;
    busy_cnt = 0;
    I2C_Busy_i = 1'b0;
    @(posedge clk); #1;
    Reset_n_i = 1'b1;
    checks++;
    if ({Done_o, Error_o, I2C_StartProcess_o, I2C_FIFOWrite_o, I2C_FIFOReadNext_o,
         I2C_ReceiveSend_n_o, I2C_ReadCount_o, I2C_Data_o} !== 17'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got nonzero control outputs want all 0");
    end
    checks++;
    if (Byte0_o !== 8'h00 || Byte1_o !== 8'h00) begin
      errors++; $display("FAIL reset_mid_bytes: got %02h/%02h want 00/00", Byte1_o, Byte0_o);
    end
    m_b0 = 8'h00; m_b1 = 8'h00;
    repeat (30) begin @(posedge clk); #1; end
    checks++;
    if (n_done !== 0 || n_err !== 0) begin
      errors++; $display("FAIL reset_mid_abort: got done %0d err %0d want 0 0", n_done, n_err);
    end
    run_query(1'b1, 1'b0, 8'($urandom), 8'($urandom), 2, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int r, b, ea;
      r  = int'($urandom_range(0, 2));
      b  = int'($urandom_range(1, 5));
      ea = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_query(r != 1, r != 0, 8'($urandom), 8'($urandom), b, ea, 1'($urandom_range(0, 1)),
                "random");
    end
  endtask

  initial begin
    test_reset();
    test_local_example();
    test_remote();
    test_both_queries();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
